// File: rtl/pulse_bcd_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pulse_cnt_pkg
// Brief    : Shared constants, scan-state type and segment decoder for the
//            pulse BCD counter and its display scanner.
// Revision : 1.0 - initial release
// ============================================================================
package pulse_cnt_pkg;

  localparam int DIGITS = 4;

  // Active-low segment codes, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    SCAN_D0 = 2'd0,
    SCAN_D1 = 2'd1,
    SCAN_D2 = 2'd2,
    SCAN_D3 = 2'd3
  } scan_state_t;

  // Non-BCD nibbles (A-F) cannot occur in the count; they show blank
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_bcd_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : pulse_bcd_counter_if
// Brief    : Control inputs and count/display outputs of the pulse BCD
//            counter. The slave side is the counter, the master side is
//            whatever drives the strobe and watches the count.
// Revision : 1.0 - initial release
// ============================================================================
interface pulse_bcd_counter_if;
  import pulse_cnt_pkg::*;

  logic                  Pulse_in;
  logic                  Clear;
  logic                  Hold;
  logic [4*DIGITS-1:0]   Count;
  logic                  Overflow;
  logic [DIGITS-1:0]     Anodes;
  logic [6:0]            Segments;

  modport master (
    output Pulse_in, Clear, Hold,
    input  Count, Overflow, Anodes, Segments
  );

  modport slave (
    input  Pulse_in, Clear, Hold,
    output Count, Overflow, Anodes, Segments
  );

endinterface
`default_nettype wire

// File: rtl/pulse_bcd_counter_scan.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan
// Brief    : Refresh divider, 4-digit scan FSM, segment decoder and
//            registered common-anode drive for a BCD value.
//            Optional: LEADING_ZERO_BLANK_EN blanks leading zero digits
//            (digit0 is always shown).
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan
  import pulse_cnt_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  wire                 CLK,
  input  wire                 Reset,
  input  wire [4*DIGITS-1:0]  bcd,
  output logic [DIGITS-1:0]   Anodes,
  output logic [6:0]          Segments
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0]  r_div;
  logic              w_tick;
  scan_state_t       r_state;
  scan_state_t       w_state_next;
  logic [DIGITS-1:0] r_anodes;
  logic [DIGITS-1:0] w_anodes_next;
  logic [6:0]        r_segments;
  logic [6:0]        w_segments_next;
  logic [3:0]        w_digit;
  logic              w_digit_blank;
  logic [DIGITS-1:0] w_blank;

  assign w_tick = (r_div == DIV_LAST);

  // Refresh divider: counts 0..REFRESH_DIV-1, terminal count advances the scan
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic w_zero_above;

  // A digit above digit0 is blank when it and every higher digit are zero
  always_comb begin
    w_blank      = '0;
    w_zero_above = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      w_zero_above = w_zero_above & (bcd[4*k +: 4] == 4'd0);
      w_blank[k]   = w_zero_above;
    end
  end
`else
  assign w_blank = '0;
`endif

  // Scan state register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state <= SCAN_D0;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next scan state plus the anode/segment pattern for the current digit
  always_comb begin
    w_state_next  = r_state;
    w_anodes_next = '1;
    w_digit       = bcd[3:0];
    w_digit_blank = w_blank[0];
    case (r_state)
      SCAN_D0: begin
        if (w_tick) w_state_next = SCAN_D1;
        w_anodes_next = 4'b1110;
        w_digit       = bcd[3:0];
        w_digit_blank = w_blank[0];
      end
      SCAN_D1: begin
        if (w_tick) w_state_next = SCAN_D2;
        w_anodes_next = 4'b1101;
        w_digit       = bcd[7:4];
        w_digit_blank = w_blank[1];
      end
      SCAN_D2: begin
        if (w_tick) w_state_next = SCAN_D3;
        w_anodes_next = 4'b1011;
        w_digit       = bcd[11:8];
        w_digit_blank = w_blank[2];
      end
      SCAN_D3: begin
        if (w_tick) w_state_next = SCAN_D0;
        w_anodes_next = 4'b0111;
        w_digit       = bcd[15:12];
        w_digit_blank = w_blank[3];
      end
      default: begin
        w_state_next = SCAN_D0;
      end
    endcase
    w_segments_next = w_digit_blank ? SEG_BLANK : seg_decode(w_digit);
  end

  // Output registers: one cycle behind the scan state, reset to digit0 showing 0
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_anodes   <= 4'b1110;
      r_segments <= SEG_0;
    end else begin
      r_anodes   <= w_anodes_next;
      r_segments <= w_segments_next;
    end
  end

  assign Anodes   = r_anodes;
  assign Segments = r_segments;

endmodule
`default_nettype wire

// File: rtl/pulse_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module   : pulse_bcd_counter
// Brief    : Counts rising edges of the pulse-detector strobe as a 4-digit
//            BCD value with sticky overflow, and scans it onto a multiplexed
//            common-anode 7-segment display.
//            Optional: LEADING_ZERO_BLANK_EN (display only, see seven_seg_scan).
// Revision : 1.0 - initial release
// ============================================================================
module pulse_bcd_counter
  import pulse_cnt_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  wire                 CLK,
  input  wire                 Reset,
  pulse_bcd_counter_if.slave  bus
);

  logic                r_prev;
  logic [4*DIGITS-1:0] r_count;
  logic                r_overflow;
  logic                w_inc;
  logic [4*DIGITS-1:0] w_count_inc;
  logic                w_carry;

  // prev resets high so a strobe already asserted at reset release is ignored;
  // it keeps sampling during Hold so releasing Hold mid-pulse does not count
  assign w_inc = bus.Pulse_in & ~r_prev & ~bus.Hold;

  // Strobe history for rising-edge detection
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= bus.Pulse_in;
    end
  end

  // Ripple-carry BCD increment; w_carry left set means 9999 wrapped to 0000
  always_comb begin
    w_count_inc = r_count;
    w_carry     = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_carry) begin
        if (r_count[4*k +: 4] == 4'd9) begin
          w_count_inc[4*k +: 4] = 4'd0;
        end else begin
          w_count_inc[4*k +: 4] = r_count[4*k +: 4] + 4'd1;
          w_carry               = 1'b0;
        end
      end
    end
  end

  // Count and sticky overflow; Clear takes priority over a coincident edge
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (bus.Clear) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_inc) begin
      r_count <= w_count_inc;
      if (w_carry) r_overflow <= 1'b1;
    end
  end

  assign bus.Count    = r_count;
  assign bus.Overflow = r_overflow;

  seven_seg_scan #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scan (
    .CLK      (CLK),
    .Reset    (Reset),
    .bcd      (r_count),
    .Anodes   (bus.Anodes),
    .Segments (bus.Segments)
  );

endmodule
`default_nettype wire

// File: tb/tb_pulse_bcd_counter.sv
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pulse_bcd_counter
// Brief    : Self-checking bench for pulse_bcd_counter (REFRESH_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_bcd_counter;

  logic CLK = 1'b0;
  logic Reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  pulse_bcd_counter_if bus();

  pulse_bcd_counter #(.REFRESH_DIV(4)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        p;
    logic        clr;
    logic        hold;
    logic [15:0] cnt;
    logic        ovf;
  } vec_t;

  vec_t vecs[12];

  // Reference model state: plain integer count, rules applied per cycle
  int   m_count;
  logic m_ovf;
  logic m_last_pin;

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] b;
    b[15:12] = 4'((n / 1000) % 10);
    b[11:8]  = 4'((n / 100) % 10);
    b[7:4]   = 4'((n / 10) % 10);
    b[3:0]   = 4'(n % 10);
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input int width, input int gap);
    bus.Pulse_in = 1'b1;
    repeat (width) tick();
    bus.Pulse_in = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse(1, 1);
  endtask

  task automatic do_clear();
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_an[4];
    logic [6:0] exp_seg[4];
    logic [3:0] prev_an;
    logic       found;
    logic       rin;
    int         cyc;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'h0042, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'h0042, 1'b0};  // rise under Hold
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 16'h0042, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h0042, 1'b0};  // Hold released while high
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'h0042, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h0042, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h0043, 1'b0};  // ordinary rise counts
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0043, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};  // Clear beats rise
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};  // that edge is lost
    vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 16'h0001, 1'b0};

    exp_an[0]  = 4'b1101; exp_seg[0] = 7'b1000000;  // digit1 = 0
    exp_an[1]  = 4'b1011; exp_seg[1] = 7'b0110000;  // digit2 = 3
    exp_an[2]  = 4'b0111;
`ifdef LEADING_ZERO_BLANK_EN
    exp_seg[2] = 7'b1111111;                        // digit3 leading zero
`else
    exp_seg[2] = 7'b1000000;                        // digit3 = 0
`endif
    exp_an[3]  = 4'b1110; exp_seg[3] = 7'b0010010;  // digit0 = 5

    bus.Pulse_in = 1'b1;
    bus.Clear    = 1'b0;
    bus.Hold     = 1'b0;

    // Reset state
    #12;
    check("rst_count", 32'(bus.Count), 32'h0000);
    check("rst_ovf", 32'(bus.Overflow), 0);
    check("rst_anodes", 32'(bus.Anodes), 32'b1110);
    check("rst_segments", 32'(bus.Segments), 32'b1000000);
    @(negedge CLK);
    Reset = 1'b1;

    // Strobe high at reset release is not counted
    repeat (5) tick();
    check("held_high_no_count", 32'(bus.Count), 32'h0000);
    bus.Pulse_in = 1'b0;
    tick();
    bus.Pulse_in = 1'b1;
    tick();
    check("first_rise_latency", 32'(bus.Count), 32'h0001);
    bus.Pulse_in = 1'b0;
    tick();

    // Pulse widths do not matter
    do_clear();
    pulse(1, 2); pulse(3, 2); pulse(10, 2);
    pulse(2, 2); pulse(2, 2); pulse(2, 2);
    check("widths_count", 32'(bus.Count), 32'h0006);

    // Carries and wrap
    do_clear();
    pulses(9);
    check("cnt_0009", 32'(bus.Count), 32'h0009);
    pulses(1);
    check("carry_0010", 32'(bus.Count), 32'h0010);
    pulses(89);
    check("cnt_0099", 32'(bus.Count), 32'h0099);
    pulses(1);
    check("carry_0100", 32'(bus.Count), 32'h0100);
    pulses(9899);
    check("cnt_9999", 32'(bus.Count), 32'h9999);
    check("ovf_before_wrap", 32'(bus.Overflow), 0);
    pulses(1);
    check("wrap_0000", 32'(bus.Count), 32'h0000);
    check("wrap_ovf", 32'(bus.Overflow), 1);
    pulses(1);
    check("after_wrap_0001", 32'(bus.Count), 32'h0001);
    check("ovf_sticky", 32'(bus.Overflow), 1);
    do_clear();
    check("clear_count", 32'(bus.Count), 32'h0000);
    check("clear_ovf", 32'(bus.Overflow), 0);

    // Hold / Clear interaction table, starting from 0042
    pulses(42);
    for (int i = 0; i < 12; i++) begin
      bus.Pulse_in = vecs[i].p;
      bus.Clear    = vecs[i].clr;
      bus.Hold     = vecs[i].hold;
      tick();
      check($sformatf("vec%0d_count", i), 32'(bus.Count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_ovf", i), 32'(bus.Overflow), 32'(vecs[i].ovf));
    end
    bus.Pulse_in = 1'b0;
    bus.Clear    = 1'b0;
    bus.Hold     = 1'b0;
    tick();

    // Asynchronous reset mid-cycle at 0517, while a digit other than 0 is lit
    do_clear();
    pulses(517);
    check("cnt_0517", 32'(bus.Count), 32'h0517);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.Anodes != 4'b1110) found = 1'b1;
      else tick();
    end
    check("anodes_moved_before_reset", 32'(found), 1);
    #2;
    Reset = 1'b0;
    #1;
    check("async_rst_count", 32'(bus.Count), 32'h0000);
    check("async_rst_ovf", 32'(bus.Overflow), 0);
    check("async_rst_anodes", 32'(bus.Anodes), 32'b1110);
    check("async_rst_segments", 32'(bus.Segments), 32'b1000000);
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
    tick();

    // Display scan at 0305
    pulses(305);
    check("cnt_0305", 32'(bus.Count), 32'h0305);
    found   = 1'b0;
    prev_an = bus.Anodes;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (bus.Anodes == 4'b1101 && prev_an == 4'b1110) found = 1'b1;
      else prev_an = bus.Anodes;
    end
    check("scan_reached_d1", 32'(found), 1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("scan%0d_anodes", i), 32'(bus.Anodes), 32'(exp_an[i/4]));
      check($sformatf("scan%0d_segments", i), 32'(bus.Segments), 32'(exp_seg[i/4]));
      tick();
    end

    // Randomized traffic against the integer reference model
    m_count    = 305;
    m_ovf      = 1'b0;
    m_last_pin = bus.Pulse_in;
    for (cyc = 0; cyc < 3000; cyc++) begin
      rin          = 1'($urandom_range(0, 1));
      bus.Pulse_in = rin;
      bus.Clear    = ($urandom_range(0, 63) == 0);
      bus.Hold     = ($urandom_range(0, 7) == 0);
      if (bus.Clear) begin
        m_count = 0;
        m_ovf   = 1'b0;
      end else if (rin && !m_last_pin && !bus.Hold) begin
        m_count = m_count + 1;
        if (m_count == 10000) begin
          m_count = 0;
          m_ovf   = 1'b1;
        end
      end
      m_last_pin = rin;
      tick();
      check($sformatf("rand%0d_count", cyc), 32'(bus.Count), 32'(to_bcd(m_count)));
      check($sformatf("rand%0d_ovf", cyc), 32'(bus.Overflow), 32'(m_ovf));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
